burst_mem_responder: RTL
========================

Name: burst_mem_responder

Overview:
Synthesizable responder for the 64-bit, 4-beat burst memory interface driven by cacheline_adaptor. It is the memory side of the bmem_* handshake and fronts an on-chip line store, so the full cache hierarchy can run against a deterministic, latency-programmable memory in FPGA bring-up and unit benches. It accepts one line read or line write at a time. For each accepted request it returns or consumes exactly four 64-bit beats.

Parameters:
INDEX_BITS, 8, log2 of stored 256-bit lines (default 256 lines = 8 KiB); address bits above the index alias.
LATENCY, 4, cycles from request acceptance to first resp beat; legal range 1..255.

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  synchronous active-high reset
bmem_address  in  32  byte address of line; bits [4:0] ignored
bmem_read  in  1  line read request, held until last beat
bmem_write  in  1  line write request, held until last beat
bmem_wdata  in  64  write beat, must be valid in every resp cycle of a write
bmem_rdata  out  64  read beat, valid only when bmem_resp=1 on a read
bmem_resp  out  1  beat strobe, high for exactly 4 consecutive cycles per request
proto_err  out  1  sticky protocol-violation flag, cleared only by rst

Behaviour:
- Reset (sync, active-high): state=IDLE, bmem_resp=0, bmem_rdata=0, proto_err=0, counters=0. Array contents are not reset. Reset during WAIT/BURST aborts the request immediately. Beats already written stay committed.
- Line index = bmem_address[5 +: INDEX_BITS]. Address, index and op are latched on acceptance. Later changes to bmem_address are ignored until IDLE.
- FSM states: IDLE, WAIT, BURST, DONE.
  - IDLE: exactly one of read/write high → latch op/index. Go to BURST if LATENCY=1, else WAIT with lat_cnt=LATENCY-2.
  - IDLE: both read and write high → set proto_err, stay IDLE, no response.
  - WAIT: lat_cnt decrements each cycle; at 0 → BURST with beat=0.
  - BURST: bmem_resp=1 and beat=0..3 increments each cycle; beat 3 → DONE.
  - DONE: bmem_resp=0 and requests are ignored for this one cycle (absorbs the initiator's deassert lag) → IDLE.
- Timing: request first seen in IDLE at cycle C0 → beats at C0+LATENCY .. C0+LATENCY+3. Earliest next acceptance is C0+LATENCY+5.
- Read beats: bmem_rdata = line[index].beat[beat] during BURST, 0 otherwise. Beat 0 is the lowest 64 bits of the line, so the address offset never reorders beats.
- Write beats: in each BURST cycle, line[index].beat[beat] <= bmem_wdata. A full line is always written; there is no mask.
- Read-after-write to the same line returns the new data. This holds because the write commits on its resp cycles and the next read cannot start until after DONE.
- Request dropped (read/write low) during WAIT or BURST → set proto_err; the burst still completes all 4 beats, and writes still commit.
- Op switched mid-request (read↔write) → set proto_err; the latched op governs.
- Counter widths: lat_cnt is 8 bits, beat is 2 bits. The beat counter ends the burst explicitly at 3 rather than relying on 2-bit wrap.

Decomposition:
- Package burst_mem_pkg holds:
  - enum bmem_state_t {IDLE, WAIT, BURST, DONE}
  - BEATS=4, BEAT_W=64, LINE_W=256, LINE_OFFSET=5
- Sub-module burst_mem_array(INDEX_BITS) holds the store as [2**INDEX_BITS][4][64]:
  - one combinational read port (index, beat)
  - one synchronous write port (we, index, beat, data)
- The top holds the FSM, latches and error logic.

Test Plan:
- Write then read, LATENCY=4: write addr 0x0000_0040 with beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 → resp at C0+4..C0+7. A read of 0x0000_0040 returns the same four beats in order, with first beat at C0'+4.
- LATENCY=1 back-to-back: read accepted at C0 → resp at C0+1..C0+4, low at C0+5. A second read held from C0+5 is ignored in DONE and accepted at C0+6 (DONE still counts it from its true C0).
- Aliasing: with INDEX_BITS=8, write 0x0000_2000 (index 0), then read 0x0000_0000 → identical data. Offset bits: read of 0x0000_001C returns beat 0 first.
- Protocol errors: read and write high together in IDLE → proto_err=1 next cycle, bmem_resp stays 0. Read dropped in WAIT → proto_err=1, 4 resp beats still emitted, proto_err remains 1 until rst.
- Mid-burst reset: write with rst asserted in the cycle after beat 1 → resp=0 and state IDLE the following cycle. A later read shows beats 0–1 new, beats 2–3 old.
- Randomized: 10k random line reads/writes with random LATENCY in 1..16 against a scoreboard → exactly 4 resp cycles per request, all data matches, proto_err=0.

Source files
------------

// File: rtl/burst_mem_pkg.sv
// Shared types and constants for the burst memory responder.
//   bmem_state_t : responder FSM states
//   BEATS        : beats per line transfer
//   BEAT_W       : width of one beat in bits
//   LINE_W       : width of one stored line in bits
//   LINE_OFFSET  : byte-offset bits below the line index in bmem_address
package burst_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        BURST = 2'd2,
        DONE  = 2'd3
    } bmem_state_t;

    localparam int BEATS       = 4;
    localparam int BEAT_W      = 64;
    localparam int LINE_W      = BEATS * BEAT_W;
    localparam int LINE_OFFSET = 5;

endpackage

// File: rtl/burst_mem_array.sv
// Line store for the burst responder: 2**INDEX_BITS lines of 4 x 64-bit beats.
//   clk      : clock for the write port
//   we       : write enable for one beat
//   wr_index : line index written
//   wr_beat  : beat within the line written
//   wr_data  : beat data written
//   rd_index : line index read (combinational)
//   rd_beat  : beat within the line read (combinational)
//   rd_data  : selected beat
module burst_mem_array
    import burst_mem_pkg::*;
#(
    parameter int INDEX_BITS = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [INDEX_BITS-1:0] wr_index,
    input  logic [1:0]            wr_beat,
    input  logic [BEAT_W-1:0]     wr_data,
    input  logic [INDEX_BITS-1:0] rd_index,
    input  logic [1:0]            rd_beat,
    output logic [BEAT_W-1:0]     rd_data
);

    localparam int LINES = 2 ** INDEX_BITS;

    logic [BEAT_W-1:0] lane_rdata [BEATS];

    // One storage lane per beat position, so each lane is a plain
    // single-write-port memory and the beat select is only a read mux.
    generate
        for (genvar gi = 0; gi < BEATS; gi++) begin : g_lane
            logic [BEAT_W-1:0] lane_mem [LINES];

            always_ff @(posedge clk) begin
                if (we && (wr_beat == 2'(gi))) begin
                    lane_mem[wr_index] <= wr_data;
                end
            end

            assign lane_rdata[gi] = lane_mem[rd_index];
        end
    endgenerate

    assign rd_data = lane_rdata[rd_beat];

endmodule

// File: rtl/burst_mem_responder.sv
// Memory-side responder for the 64-bit, 4-beat bmem_* burst interface.
// Accepts one line read or write at a time, waits LATENCY cycles, then
// streams or absorbs four beats against an on-chip line store.
//   clk          : clock
//   rst          : synchronous active-high reset
//   bmem_address : byte address of the line (bits [4:0] ignored)
//   bmem_read    : line read request, held through the last beat
//   bmem_write   : line write request, held through the last beat
//   bmem_wdata   : write beat, sampled on every resp cycle of a write
//   bmem_rdata   : read beat, valid while bmem_resp is high on a read
//   bmem_resp    : beat strobe, four consecutive cycles per request
//   proto_err    : sticky protocol-violation flag, cleared by rst
module burst_mem_responder
    import burst_mem_pkg::*;
#(
    parameter int INDEX_BITS = 8,
    parameter int LATENCY    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       bmem_address,
    input  logic              bmem_read,
    input  logic              bmem_write,
    input  logic [BEAT_W-1:0] bmem_wdata,
    output logic [BEAT_W-1:0] bmem_rdata,
    output logic              bmem_resp,
    output logic              proto_err
);

    localparam logic [31:0] INDEX_MASK = ((32'd1 << INDEX_BITS) - 32'd1) << LINE_OFFSET;

    bmem_state_t           state_reg;
    logic                  op_write_reg;
    logic [INDEX_BITS-1:0] index_reg;
    logic [7:0]            lat_cnt_reg;
    logic [1:0]            beat_reg;
    logic                  resp_reg;
    logic                  proto_err_reg;

    logic                  array_we;
    logic [BEAT_W-1:0]     array_rdata;
    logic                  req_violation;
    logic                  unused_addr_bits;

    // Offset and aliased upper address bits carry no information here.
    assign unused_addr_bits = ^(bmem_address & ~INDEX_MASK);

    // While a request is in flight the initiator must keep exactly the
    // latched op asserted; anything else is a protocol violation.
    assign req_violation = op_write_reg ? (!bmem_write || bmem_read)
                                        : (!bmem_read  || bmem_write);

    // Reset wins over a pending beat so an aborted write stops committing
    // on the very cycle reset is seen.
    assign array_we = (state_reg == BURST) && op_write_reg && !rst;

    burst_mem_array #(
        .INDEX_BITS(INDEX_BITS)
    ) u_array (
        .clk      (clk),
        .we       (array_we),
        .wr_index (index_reg),
        .wr_beat  (beat_reg),
        .wr_data  (bmem_wdata),
        .rd_index (index_reg),
        .rd_beat  (beat_reg),
        .rd_data  (array_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            op_write_reg  <= 1'b0;
            index_reg     <= '0;
            lat_cnt_reg   <= 8'd0;
            beat_reg      <= 2'd0;
            resp_reg      <= 1'b0;
            proto_err_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bmem_read && bmem_write) begin
                        proto_err_reg <= 1'b1;
                    end else if (bmem_read || bmem_write) begin
                        op_write_reg <= bmem_write;
                        index_reg    <= bmem_address[LINE_OFFSET +: INDEX_BITS];
                        beat_reg     <= 2'd0;
                        if (LATENCY == 1) begin
                            state_reg <= BURST;
                            resp_reg  <= 1'b1;
                        end else begin
                            // The IDLE->WAIT and WAIT->BURST edges each
                            // account for one cycle of the latency.
                            state_reg   <= WAIT;
                            lat_cnt_reg <= 8'(LATENCY - 2);
                        end
                    end
                end
                WAIT: begin
                    if (req_violation) begin
                        proto_err_reg <= 1'b1;
                    end
                    if (lat_cnt_reg == 8'd0) begin
                        state_reg <= BURST;
                        resp_reg  <= 1'b1;
                        beat_reg  <= 2'd0;
                    end else begin
                        lat_cnt_reg <= lat_cnt_reg - 8'd1;
                    end
                end
                BURST: begin
                    if (req_violation) begin
                        proto_err_reg <= 1'b1;
                    end
                    if (beat_reg == 2'd3) begin
                        state_reg <= DONE;
                        resp_reg  <= 1'b0;
                    end else begin
                        beat_reg <= beat_reg + 2'd1;
                    end
                end
                DONE: begin
                    // Requests seen here are the initiator's late deassert.
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bmem_resp  = resp_reg;
    assign bmem_rdata = (resp_reg && !op_write_reg) ? array_rdata : '0;
    assign proto_err  = proto_err_reg;

endmodule
